// File: rtl/direct_trans_ingr_sender_if.sv
// Stream bundle for the ingress-RX sender: header and payload in, request out,
// response in, data out. "master" is the sender's view, "slave" is the environment's.
interface direct_trans_ingr_sender_if #(
    parameter int unsigned DATA_W = 512
);
    logic              s_axis_hdr_TVALID;
    logic              s_axis_hdr_TREADY;
    logic [63:0]       s_axis_hdr_TDATA;
    logic              s_axis_pld_TVALID;
    logic              s_axis_pld_TREADY;
    logic [DATA_W-1:0] s_axis_pld_TDATA;
    logic              m_axis_ingr_rx_req_TVALID;
    logic              m_axis_ingr_rx_req_TREADY;
    logic [63:0]       m_axis_ingr_rx_req_TDATA;
    logic              s_axis_ingr_rx_resp_TVALID;
    logic              s_axis_ingr_rx_resp_TREADY;
    logic [63:0]       s_axis_ingr_rx_resp_TDATA;
    logic              m_axis_ingr_rx_data_TVALID;
    logic              m_axis_ingr_rx_data_TREADY;
    logic [DATA_W-1:0] m_axis_ingr_rx_data_TDATA;

    modport master (
        input  s_axis_hdr_TVALID, s_axis_hdr_TDATA,
        output s_axis_hdr_TREADY,
        input  s_axis_pld_TVALID, s_axis_pld_TDATA,
        output s_axis_pld_TREADY,
        output m_axis_ingr_rx_req_TVALID, m_axis_ingr_rx_req_TDATA,
        input  m_axis_ingr_rx_req_TREADY,
        input  s_axis_ingr_rx_resp_TVALID, s_axis_ingr_rx_resp_TDATA,
        output s_axis_ingr_rx_resp_TREADY,
        output m_axis_ingr_rx_data_TVALID, m_axis_ingr_rx_data_TDATA,
        input  m_axis_ingr_rx_data_TREADY
    );

    modport slave (
        output s_axis_hdr_TVALID, s_axis_hdr_TDATA,
        input  s_axis_hdr_TREADY,
        output s_axis_pld_TVALID, s_axis_pld_TDATA,
        input  s_axis_pld_TREADY,
        input  m_axis_ingr_rx_req_TVALID, m_axis_ingr_rx_req_TDATA,
        output m_axis_ingr_rx_req_TREADY,
        output s_axis_ingr_rx_resp_TVALID, s_axis_ingr_rx_resp_TDATA,
        input  s_axis_ingr_rx_resp_TREADY,
        input  m_axis_ingr_rx_data_TVALID, m_axis_ingr_rx_data_TDATA,
        output m_axis_ingr_rx_data_TREADY
    );
endinterface

// File: rtl/direct_trans_ingr_sender.sv
// Ingress-RX feeder: header -> request -> response check -> payload beats forwarded,
// with sticky fault reporting and a completed-frame counter.
module direct_trans_ingr_sender #(
    parameter int unsigned RESP_TIMEOUT = 65535
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    direct_trans_ingr_sender_if.master     bus,
    output logic                           detect_fault,
    output logic [2:0]                     fault_cause,
    output logic [31:0]                    frame_count
);
    localparam int unsigned TO_W = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_RESP, S_DATA, S_DISCARD
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       len_q, len_d;
    logic [15:0]       chid_q, chid_d;
    logic [26:0]       beats_q, beats_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              hdr_tready_q, hdr_tready_d;
    logic              resp_tready_q, resp_tready_d;
    logic              req_tvalid_q, req_tvalid_d;
    logic [2:0]        fault_q, fault_d;
    logic              detect_q, detect_d;
    logic [31:0]       frame_q, frame_d;

    logic              hdr_acc, req_acc, resp_acc, pld_acc, pld_tready;
    logic              resp_match;
    logic [32:0]       len_round;
    logic              unused_bits;

    assign unused_bits = ^{bus.s_axis_hdr_TDATA[63:48], bus.s_axis_ingr_rx_resp_TDATA[63:48]};

    // Payload path is combinational; in DISCARD beats are sunk without reaching data out.
    assign pld_tready = (state_q == S_DATA) ? bus.m_axis_ingr_rx_data_TREADY
                                            : (state_q == S_DISCARD);
    assign bus.s_axis_pld_TREADY          = pld_tready;
    assign bus.m_axis_ingr_rx_data_TVALID = (state_q == S_DATA) && bus.s_axis_pld_TVALID;
    assign bus.m_axis_ingr_rx_data_TDATA  = bus.s_axis_pld_TDATA;

    assign bus.s_axis_hdr_TREADY          = hdr_tready_q;
    assign bus.s_axis_ingr_rx_resp_TREADY = resp_tready_q;
    assign bus.m_axis_ingr_rx_req_TVALID  = req_tvalid_q;
    assign bus.m_axis_ingr_rx_req_TDATA   = {16'h0, chid_q, len_q};
    assign detect_fault = detect_q;
    assign fault_cause  = fault_q;
    assign frame_count  = frame_q;

    assign hdr_acc    = bus.s_axis_hdr_TVALID && hdr_tready_q;
    assign req_acc    = req_tvalid_q && bus.m_axis_ingr_rx_req_TREADY;
    assign resp_acc   = bus.s_axis_ingr_rx_resp_TVALID && resp_tready_q;
    assign pld_acc    = bus.s_axis_pld_TVALID && pld_tready;
    assign resp_match = (bus.s_axis_ingr_rx_resp_TDATA[31:0] == len_q) &&
                        (bus.s_axis_ingr_rx_resp_TDATA[47:32] == chid_q);
    assign len_round  = {1'b0, bus.s_axis_hdr_TDATA[31:0]} + 33'd63;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        chid_d       = chid_q;
        beats_d      = beats_q;
        to_cnt_d     = to_cnt_q;
        req_tvalid_d = req_tvalid_q;
        fault_d      = fault_q;
        frame_d      = frame_q;
        unique case (state_q)
            S_IDLE: begin
                if (hdr_acc) begin
                    len_d   = bus.s_axis_hdr_TDATA[31:0];
                    chid_d  = bus.s_axis_hdr_TDATA[47:32];
                    beats_d = len_round[32:6];
                    if (bus.s_axis_hdr_TDATA[31:0] == '0) begin
                        fault_d[2] = 1'b1;
                    end else begin
                        state_d      = S_REQ;
                        req_tvalid_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (req_acc) begin
                    req_tvalid_d = 1'b0;
                    to_cnt_d     = '0;
                    state_d      = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                // A response in the expiry cycle takes priority over the timeout.
                if (resp_acc) begin
                    if (resp_match) begin
                        state_d = S_DATA;
                    end else begin
                        fault_d[0] = 1'b1;
                        state_d    = S_DISCARD;
                    end
                end else if (to_cnt_q == TO_W'(RESP_TIMEOUT - 1)) begin
                    fault_d[1] = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_DATA, S_DISCARD: begin
                if (pld_acc) begin
                    beats_d = beats_q - 1'b1;
                    if (beats_q == 27'd1) begin
                        state_d = S_IDLE;
                        if (state_q == S_DATA) frame_d = frame_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        hdr_tready_d  = (state_d == S_IDLE);
        resp_tready_d = (state_d == S_IDLE) || (state_d == S_WAIT_RESP);
        detect_d      = |fault_d;
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            chid_q        <= '0;
            beats_q       <= '0;
            to_cnt_q      <= '0;
            hdr_tready_q  <= 1'b0;
            resp_tready_q <= 1'b0;
            req_tvalid_q  <= 1'b0;
            fault_q       <= '0;
            detect_q      <= 1'b0;
            frame_q       <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            chid_q        <= chid_d;
            beats_q       <= beats_d;
            to_cnt_q      <= to_cnt_d;
            hdr_tready_q  <= hdr_tready_d;
            resp_tready_q <= resp_tready_d;
            req_tvalid_q  <= req_tvalid_d;
            fault_q       <= fault_d;
            detect_q      <= detect_d;
            frame_q       <= frame_d;
        end
    end
endmodule

// File: tb/tb_direct_trans_ingr_sender.sv
// Scoreboard bench for direct_trans_ingr_sender: directed frames, expected request
// words and data beats queued at issue time, popped by an independent monitor.
module tb_direct_trans_ingr_sender;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        detect_fault;
    logic [2:0]  fault_cause;
    logic [31:0] frame_count;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    logic [63:0]  req_q[$];
    logic [511:0] dat_q[$];
    logic         tog_en = 1'b0;

    direct_trans_ingr_sender_if bus ();

    direct_trans_ingr_sender #(.RESP_TIMEOUT(16)) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .bus          (bus),
        .detect_fault (detect_fault),
        .fault_cause  (fault_cause),
        .frame_count  (frame_count)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] pat(input logic [15:0] f, input logic [15:0] b);
        return {16{f, b}};
    endfunction

    // Monitor: pops expectations whenever a transfer is about to complete.
    initial forever begin
        @(negedge ap_clk);
        if (ap_rst_n) begin
            if (bus.m_axis_ingr_rx_req_TVALID && bus.m_axis_ingr_rx_req_TREADY) begin
                if (req_q.size() == 0) check("unexpected_req", bus.m_axis_ingr_rx_req_TDATA, '0);
                else check("req_tdata", bus.m_axis_ingr_rx_req_TDATA, req_q.pop_front());
            end
            if (bus.m_axis_ingr_rx_data_TVALID && bus.m_axis_ingr_rx_data_TREADY) begin
                if (dat_q.size() == 0) check("unexpected_data", 1'b1, 1'b0);
                else check("data_beat", bus.m_axis_ingr_rx_data_TDATA, dat_q.pop_front());
            end
        end
    end

    // Downstream data ready: held high, or toggling every cycle when tog_en is set.
    initial forever begin
        @(posedge ap_clk); #1;
        bus.m_axis_ingr_rx_data_TREADY = tog_en ? ~bus.m_axis_ingr_rx_data_TREADY : 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_hdr(input logic [63:0] d);
        bus.s_axis_hdr_TVALID = 1'b1;
        bus.s_axis_hdr_TDATA  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge ap_clk);
            if (bus.s_axis_hdr_TREADY) begin
                @(posedge ap_clk); #1;
                bus.s_axis_hdr_TVALID = 1'b0;
                return;
            end
        end
        check("hdr_wait_timeout", 1'b1, 1'b0);
        bus.s_axis_hdr_TVALID = 1'b0;
    endtask

    task automatic do_req_wait();
        for (int i = 0; i < 200; i++) begin
            @(negedge ap_clk);
            if (bus.m_axis_ingr_rx_req_TVALID && bus.m_axis_ingr_rx_req_TREADY) begin
                @(posedge ap_clk); #1;
                return;
            end
        end
        check("req_wait_timeout", 1'b1, 1'b0);
    endtask

    task automatic do_resp(input logic [63:0] d);
        bus.s_axis_ingr_rx_resp_TVALID = 1'b1;
        bus.s_axis_ingr_rx_resp_TDATA  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge ap_clk);
            if (bus.s_axis_ingr_rx_resp_TREADY) begin
                @(posedge ap_clk); #1;
                bus.s_axis_ingr_rx_resp_TVALID = 1'b0;
                return;
            end
        end
        check("resp_wait_timeout", 1'b1, 1'b0);
        bus.s_axis_ingr_rx_resp_TVALID = 1'b0;
    endtask

    task automatic do_pld(input logic [511:0] d);
        bus.s_axis_pld_TVALID = 1'b1;
        bus.s_axis_pld_TDATA  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge ap_clk);
            if (bus.s_axis_pld_TREADY) begin
                @(posedge ap_clk); #1;
                bus.s_axis_pld_TVALID = 1'b0;
                return;
            end
        end
        check("pld_wait_timeout", 1'b1, 1'b0);
        bus.s_axis_pld_TVALID = 1'b0;
    endtask

    // One frame with a hand-computed beat count; data expected only when echo matches.
    task automatic run_frame(input logic [31:0] len, input logic [15:0] chid,
                             input logic [31:0] elen, input logic [15:0] echid,
                             input int unsigned nb, input logic [15:0] fid);
        logic ok;
        ok = (elen == len) && (echid == chid);
        req_q.push_back({16'h0, chid, len});
        do_hdr({16'hABCD, chid, len});
        do_req_wait();
        do_resp({16'h0, echid, elen});
        for (int unsigned b = 0; b < nb; b++) begin
            if (ok) dat_q.push_back(pat(fid, 16'(b)));
            do_pld(pat(fid, 16'(b)));
        end
        repeat (2) @(posedge ap_clk);
        #1;
    endtask

    initial begin
        ap_rst_n = 1'b0;
        bus.s_axis_hdr_TVALID = 1'b0;           bus.s_axis_hdr_TDATA = '0;
        bus.s_axis_pld_TVALID = 1'b0;           bus.s_axis_pld_TDATA = '0;
        bus.m_axis_ingr_rx_req_TREADY = 1'b1;
        bus.s_axis_ingr_rx_resp_TVALID = 1'b0;  bus.s_axis_ingr_rx_resp_TDATA = '0;
        bus.m_axis_ingr_rx_data_TREADY = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_outputs", {bus.s_axis_hdr_TREADY, bus.s_axis_pld_TREADY,
              bus.m_axis_ingr_rx_req_TVALID, bus.s_axis_ingr_rx_resp_TREADY,
              bus.m_axis_ingr_rx_data_TVALID, detect_fault, fault_cause, frame_count}, '0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        check("idle_hdr_tready", bus.s_axis_hdr_TREADY, 1'b1);

        // T1: len=128 chid=5 with request back-pressure; TDATA must hold while stalled.
        bus.m_axis_ingr_rx_req_TREADY = 1'b0;
        req_q.push_back(64'h0000_0005_0000_0080);
        do_hdr(64'h0000_0005_0000_0080);
        check("t1_req_valid_next_cycle", bus.m_axis_ingr_rx_req_TVALID, 1'b1);
        repeat (3) @(posedge ap_clk);
        #1;
        check("t1_req_tdata_stalled", bus.m_axis_ingr_rx_req_TDATA, 64'h0000_0005_0000_0080);
        bus.m_axis_ingr_rx_req_TREADY = 1'b1;
        do_req_wait();
        do_resp(64'h0000_0005_0000_0080);
        for (int unsigned b = 0; b < 2; b++) begin
            dat_q.push_back(pat(16'h1, 16'(b)));
            do_pld(pat(16'h1, 16'(b)));
        end
        repeat (2) @(posedge ap_clk);
        #1;
        check("t1_frame_count", frame_count, 32'd1);
        check("t1_detect_fault", detect_fault, 1'b0);

        // T2: rounding up and down with toggling downstream ready.
        tog_en = 1'b1;
        run_frame(32'd65, 16'd2, 32'd65, 16'd2, 2, 16'h2);
        run_frame(32'd64, 16'd2, 32'd64, 16'd2, 1, 16'h3);
        tog_en = 1'b0;
        check("t2_frame_count", frame_count, 32'd3);
        check("t2_data_all_seen", dat_q.size(), 0);

        // T3: chid echo mismatch; payload drained, nothing forwarded.
        run_frame(32'd128, 16'd5, 32'd128, 16'd6, 2, 16'h4);
        check("t3_fault_cause", fault_cause, 3'b001);
        check("t3_detect_fault", detect_fault, 1'b1);
        check("t3_frame_count", frame_count, 32'd3);
        check("t3_back_idle", bus.s_axis_hdr_TREADY, 1'b1);

        // T5: zero-length header, then a normal frame.
        do_hdr({16'h0, 16'd9, 32'd0});
        check("t5_fault_cause", fault_cause, 3'b101);
        repeat (2) @(posedge ap_clk);
        #1;
        check("t5_no_req", bus.m_axis_ingr_rx_req_TVALID, 1'b0);
        run_frame(32'd64, 16'd7, 32'd64, 16'd7, 1, 16'h5);
        check("t5_frame_count", frame_count, 32'd4);

        // T4: no response; timeout lands 16 cycles after request accept.
        req_q.push_back({16'h0, 16'd8, 32'd200});
        do_hdr({16'h0, 16'd8, 32'd200});
        do_req_wait();
        repeat (15) @(posedge ap_clk);
        #1;
        check("t4_no_timeout_at_15", fault_cause[1], 1'b0);
        @(posedge ap_clk); #1;
        check("t4_timeout_at_16", fault_cause, 3'b111);
        do_resp({16'h0, 16'd8, 32'd200});
        repeat (2) @(posedge ap_clk);
        #1;
        check("t4_late_resp_no_change", fault_cause, 3'b111);
        check("t4_frame_count", frame_count, 32'd4);
        check("t4_no_pld_consumed", bus.s_axis_pld_TREADY, 1'b0);

        // T6: reset during DATA.
        req_q.push_back({16'h0, 16'd3, 32'd128});
        do_hdr({16'h0, 16'd3, 32'd128});
        do_req_wait();
        do_resp({16'h0, 16'd3, 32'd128});
        dat_q.push_back(pat(16'h6, 16'h0));
        do_pld(pat(16'h6, 16'h0));
        check("t6_in_data", bus.s_axis_pld_TREADY, 1'b1);
        ap_rst_n = 1'b0;
        @(posedge ap_clk); #1;
        check("t6_rst_outputs", {bus.s_axis_hdr_TREADY, bus.s_axis_pld_TREADY,
              bus.m_axis_ingr_rx_req_TVALID, bus.s_axis_ingr_rx_resp_TREADY,
              bus.m_axis_ingr_rx_data_TVALID, detect_fault, fault_cause, frame_count}, '0);
        ap_rst_n = 1'b1;
        dat_q.delete();
        @(posedge ap_clk); #1;
        check("t6_idle_after_rst", bus.s_axis_hdr_TREADY, 1'b1);
        run_frame(32'd64, 16'd2, 32'd64, 16'd2, 1, 16'h7);
        check("t6_recover_frame_count", frame_count, 32'd1);
        check("t6_req_all_seen", req_q.size(), 0);
        check("t6_data_all_seen", dat_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
